mult_op_sched: RTL and testbench

//  Operand scheduler and result collector wrapped around bit16_mult. Buffers 16-bit operand pairs from a

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_op_fifo.sv | 72 +++++++
 rtl/mult_op_sched.sv | 128 ++++++++++++
 tb/tb_mult_op_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier operand scheduler.
//   OPW          operand width
//   PRODW        product width (two operands concatenated also fit in PRODW)
//   MULT_LAT_DEF default multiplier latency in cycles
//   sched_state_t  scheduler FSM encoding
package mult_pkg;

  localparam int OPW          = 16;
  localparam int PRODW        = 32;
  localparam int MULT_LAT_DEF = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CAPT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous DEPTH x W FIFO with first-word-fall-through head.
// Count, full and empty are registered; pointers wrap modulo DEPTH.
// Ports:
//   clk, srst_n  clock and synchronous active-low reset
//   push, wdata  write request and data (ignored while full)
//   pop          read request (ignored while empty); head advances next cycle
//   head         oldest entry, valid whenever empty is 0
//   full, empty  registered occupancy flags
module mult_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/mult_op_sched.sv
// Operand scheduler and result collector for a fixed-latency 16x16 multiplier.
// Operand pairs are queued in a FIFO, issued one at a time as a single-cycle
// mul_op_ld with operands held stable until the next issue, and the product is
// captured MULT_LAT cycles later into a result register.
// Ports:
//   clk, srst_n              clock, synchronous active-low reset
//   in_valid/in_ready        operand input handshake, in_opa/in_opb payload
//   mul_op_ld, mul_opa/opb   load pulse and operands to the multiplier
//   mul_out                  multiplier product
//   res_valid/res_ready      result handshake, res_data payload
//   busy                     anything pending: FSM active, FIFO non-empty or result held
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer keeps valid and payload stable until that edge; ready may
// change freely. res_ready while res_valid is 0 has no effect.
// MULT_LAT must be at least 2.
module mult_op_sched
  import mult_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opa,
  input  logic [OPW-1:0]   in_opb,
  output logic             mul_op_ld,
  output logic [OPW-1:0]   mul_opa,
  output logic [OPW-1:0]   mul_opb,
  input  logic [PRODW-1:0] mul_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PRODW-1:0] res_data,
  output logic             busy
);

  localparam int CNTW = $clog2(MULT_LAT);
  localparam logic [CNTW-1:0] LAT_M1 = CNTW'(MULT_LAT - 1);

  sched_state_t    state;
  sched_state_t    state_nxt;
  logic [CNTW-1:0] wait_cnt;
  logic            rdy_q;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [PRODW-1:0] fifo_head;
  logic            drain;
  logic            go;

  // rdy_q keeps in_ready low during reset and for no longer than that.
  assign in_ready  = rdy_q & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign drain     = res_valid & res_ready;
  // Issue only if the result register will be free when this op captures.
  assign go        = ~fifo_empty & (~res_valid | res_ready);
  assign busy      = (state != IDLE) | ~fifo_empty | res_valid;

  mult_op_fifo #(
    .DEPTH (DEPTH),
    .W     (PRODW)
  ) u_fifo (
    .clk    (clk),
    .srst_n (srst_n),
    .push   (fifo_push),
    .wdata  ({in_opa, in_opb}),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // The head is popped on the edge that enters ISSUE, so the registered
  // operands and op_ld are already valid throughout the ISSUE cycle.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = ISSUE;
          fifo_pop  = 1'b1;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter is loaded with MULT_LAT-1 for the ISSUE cycle and counts down
  // through WAIT, so CAPT falls MULT_LAT cycles after op_ld and res_valid
  // rises one cycle after that.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rdy_q     <= 1'b0;
      mul_op_ld <= 1'b0;
      mul_opa   <= '0;
      mul_opb   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      rdy_q     <= 1'b1;
      state     <= state_nxt;
      mul_op_ld <= (state_nxt == ISSUE);
      if (fifo_pop) begin
        mul_opa  <= fifo_head[PRODW-1:OPW];
        mul_opb  <= fifo_head[OPW-1:0];
        wait_cnt <= LAT_M1;
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      // CAPT never sees a held result, so capture and drain cannot clash.
      if (state == CAPT) begin
        res_valid <= 1'b1;
        res_data  <= mul_out;
      end else if (drain) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_op_sched.sv
// Directed bench for mult_op_sched with a behavioural fixed-latency multiplier.
module tb_mult_op_sched;

  localparam int MULT_LAT = 18;
  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_opa = '0;
  logic [15:0] in_opb = '0;
  logic        mul_op_ld;
  logic [15:0] mul_opa;
  logic [15:0] mul_opb;
  logic [31:0] mul_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #50 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  mult_op_sched #(.DEPTH(4), .MULT_LAT(MULT_LAT)) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opa    (in_opa),
    .in_opb    (in_opb),
    .mul_op_ld (mul_op_ld),
    .mul_opa   (mul_opa),
    .mul_opb   (mul_opb),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  // Multiplier model: product appears MULT_LAT cycles after the op_ld edge,
  // garbage before that so an early capture is visible.
  logic [31:0] m_prod = '0;
  int          m_cnt = 0;
  always @(posedge clk) begin
    if (!srst_n) begin
      m_cnt   <= 0;
      mul_out <= GARB;
    end else if (mul_op_ld) begin
      m_prod  <= 32'(mul_opa) * 32'(mul_opb);
      m_cnt   <= MULT_LAT - 1;
      mul_out <= GARB;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) mul_out <= m_prod;
    end
  end

  // Monitor: cycle stamps for op_ld and res_valid rise, op_ld pulse widths.
  int   cyc = 0;
  int   ld_cyc = 0;
  int   rise_cyc = 0;
  int   ld_cnt = 0;
  int   ld_run = 0;
  int   max_run = 0;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mul_op_ld === 1'b1) begin
      ld_cyc <= cyc;
      ld_cnt <= ld_cnt + 1;
      ld_run <= ld_run + 1;
      if (ld_run + 1 > max_run) max_run <= ld_run + 1;
    end else begin
      ld_run <= 0;
    end
    if (res_valid === 1'b1 && rv_prev !== 1'b1) rise_cyc <= cyc;
    rv_prev <= res_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: call at a negedge; returns at the negedge after acceptance.
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input bit enq);
    bit done = 0;
    in_valid = 1'b1;
    in_opa   = a;
    in_opb   = b;
    for (int i = 0; i < 200 && !done; i++) begin
      if (in_ready === 1'b1) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("push_accept", 32'(done), 32'd1);
    if (done && enq) exp_q.push_back(exp);
  endtask

  // Scoreboard: wait for a result, compare with the queue head, consume it.
  task automatic get_result(input string tag, input bit chk_lat);
    bit seen = 0;
    logic [31:0] exp;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (res_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_expq"}, 32'(exp_q.size() > 0), 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : GARB;
      check({tag, "_data"}, res_data, exp);
      @(negedge clk);
      if (chk_lat) check({tag, "_lat"}, 32'(rise_cyc - ld_cyc), 32'(MULT_LAT + 1));
    end
  endtask

  int   ld_before;
  bit   any_flag;
  logic [31:0] held;

  initial begin
    // 1. reset / idle
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_op_ld", 32'(mul_op_ld), 32'd0);
    check("rst_opa", 32'(mul_opa), 32'd0);
    check("rst_opb", 32'(mul_opb), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    srst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    res_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_ld", 32'(ld_cnt), 32'd0);
    check("idle_no_valid", 32'(res_valid), 32'd0);

    // 2. single ops
    push_pair(16'd0, 16'd0, 32'd0, 1);
    get_result("s0", 1);
    push_pair(16'd1, 16'd4, 32'd4, 1);
    get_result("s1", 1);
    push_pair(16'd9, 16'd15, 32'd135, 1);
    get_result("s2", 1);
    push_pair(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1);
    get_result("s3", 1);
    check("s_busy_done", 32'(busy), 32'd0);

    // 3. streaming
    ld_before = ld_cnt;
    push_pair(16'd31, 16'd63, 32'd1953, 1);
    push_pair(16'd255, 16'd512, 32'd130560, 1);
    push_pair(16'd1023, 16'd2048, 32'd2095104, 1);
    push_pair(16'd4095, 16'd8195, 32'd33558525, 1);
    repeat (4) get_result("st", 0);
    check("st_ld_count", 32'(ld_cnt - ld_before), 32'd4);
    check("st_ld_pulse", 32'(max_run), 32'd1);

    // 4. backpressure
    res_ready = 1'b0;
    push_pair(16'd32767, 16'd32768, 32'h3FFF_8000, 1);
    push_pair(16'd2, 16'd3, 32'd6, 1);
    push_pair(16'd100, 16'd100, 32'd10000, 1);
    push_pair(16'd1000, 16'd7, 32'd7000, 1);
    push_pair(16'd65535, 16'd2, 32'd131070, 1);
    check("bp_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_opa   = 16'd5;
    in_opb   = 16'd5;
    any_flag = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready !== 1'b0) any_flag = 1;
      @(negedge clk);
    end
    check("bp_never_ready", 32'(any_flag), 32'd0);
    check("bp_held_valid", 32'(res_valid), 32'd1);
    check("bp_held_data", res_data, 32'h3FFF_8000);
    held = res_data;
    any_flag = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_data !== held || res_valid !== 1'b1) any_flag = 1;
      @(negedge clk);
    end
    check("bp_stable", 32'(any_flag), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    res_ready = 1'b1;
    repeat (5) get_result("bp", 0);
    check("bp_ready_back", 32'(in_ready), 32'd1);

    // 5. operand stability
    push_pair(16'd40956, 16'd47281, 32'd1936440636, 1);
    repeat (3) @(negedge clk);
    check("os_opa", 32'(mul_opa), 32'd40956);
    check("os_opb", 32'(mul_opb), 32'd47281);
    push_pair(16'd3, 16'd7, 32'd21, 1);
    repeat (8) @(negedge clk);
    check("os_opa_hold", 32'(mul_opa), 32'd40956);
    check("os_opb_hold", 32'(mul_opb), 32'd47281);
    get_result("os0", 0);
    get_result("os1", 0);
    check("os_opa_next", 32'(mul_opa), 32'd3);
    check("os_opb_next", 32'(mul_opb), 32'd7);

    // 6. reset mid-op
    push_pair(16'd32768, 16'd65535, 32'd0, 0);
    repeat (8) @(negedge clk);
    check("rm_busy", 32'(busy), 32'd1);
    check("rm_opa", 32'(mul_opa), 32'd32768);
    srst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rm_in_ready", 32'(in_ready), 32'd0);
    check("rm_opa_clr", 32'(mul_opa), 32'd0);
    srst_n = 1'b1;
    @(negedge clk);
    check("rm_rel_ready", 32'(in_ready), 32'd1);
    check("rm_empty", 32'(busy), 32'd0);
    ld_before = ld_cnt;
    any_flag = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid !== 1'b0) any_flag = 1;
      @(negedge clk);
    end
    check("rm_no_result", 32'(any_flag), 32'd0);
    check("rm_no_ld", 32'(ld_cnt - ld_before), 32'd0);
    push_pair(16'd65535, 16'd65534, 32'hFFFD_0002, 1);
    get_result("rm_next", 1);

    check("final_expq_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
